// File: rtl/slot_multichannel_ramctl_if.sv
`default_nettype none
// ============================================================================
// Module   : slot_multichannel_ramctl_if
// Brief    : Apple II slot bus and card SRAM/ROM pin bundle for the
//            multichannel RAM/ROM controller.
// Revision : 1.0  initial release
// ============================================================================
interface slot_multichannel_ramctl_if #(
  parameter int ADDR_W = 24
);
  logic              PHI1;
  logic              nDEVSEL;
  logic              nIOSEL;
  logic              nIOSTRB;
  logic [10:0]       A;
  logic              nWE;
  logic [7:0]        D_in;
  logic [7:0]        D_out;
  logic              D_oe;
  logic [7:0]        RD_in;
  logic              RD_oe;
  logic [ADDR_W-1:0] RA;
  logic              RAMCS;
  logic              nROMCS;

  modport master (
    output PHI1, nDEVSEL, nIOSEL, nIOSTRB, A, nWE, D_in, RD_in,
    input  D_out, D_oe, RD_oe, RA, RAMCS, nROMCS
  );

  modport slave (
    input  PHI1, nDEVSEL, nIOSEL, nIOSTRB, A, nWE, D_in, RD_in,
    output D_out, D_oe, RD_oe, RA, RAMCS, nROMCS
  );
endinterface
`default_nettype wire

// File: rtl/slot_multichannel_ramctl.sv
`default_nettype none
// ============================================================================
// Module   : slot_multichannel_ramctl
// Brief    : NCH auto-stepping RAM address pointers plus banked expansion-ROM
//            window for an Apple II slot card. XFER_COUNT_EN adds a 16-bit
//            DATA-access counter at offsets 0xC/0xD.
// Revision : 1.0  initial release
// ============================================================================
module slot_multichannel_ramctl #(
  parameter int NCH    = 2,
  parameter int ADDR_W = 24,
  parameter int BANK_W = 8
) (
  input logic                       C7M,
  input logic                       RES,
  slot_multichannel_ramctl_if.slave bus
);

  localparam logic [23:0] c_addr_mask = 24'hFFFFFF >> (24 - ADDR_W);
  localparam int          c_mode_w    = 2 * NCH;

  logic [2:0]          r_s;
  logic                r_phi1_q;
  logic                r_phi0seen;
  logic                r_dben;
  logic                r_csen;
  logic                r_regen;
  logic                r_ioromen;
  logic [23:0]         r_addr [NCH];
  logic [c_mode_w-1:0] r_mode;
  logic [BANK_W-1:0]   r_bank;
  logic [NCH-1:0]      r_pend;

  logic [3:0]        w_off;
  logic [1:0]        w_ch;
  logic              w_is_data;
  logic              w_dev;
  logic              w_ramdec;
  logic              w_reg_wr;
  logic              w_data_acc;
  logic              w_rom_sel;
  logic [BANK_W-1:0] w_bank_inc;
  logic [23:0]       w_sel_addr;
  logic [7:0]        w_reg_rd;
  logic [15:0]       w_xcnt;
  logic [ADDR_W-1:0] w_ra;

  // Pointer stepping keeps every bit above ADDR_W at zero.
  function automatic logic [23:0] f_step(input logic [23:0] a, input logic [1:0] m);
    logic [23:0] n;
    case (m)
      2'b01:   n = a;
      2'b10:   n = a - 24'd1;
      default: n = a + 24'd1;
    endcase
    return n & c_addr_mask;
  endfunction

  assign w_off      = bus.A[3:0];
  assign w_ch       = w_off[3:2];
  assign w_is_data  = (int'(w_ch) < NCH) && (w_off[1:0] == 2'd3);
  assign w_dev      = ~bus.nDEVSEL & r_regen;
  assign w_ramdec   = w_dev & w_is_data;
  assign w_reg_wr   = w_dev & ~bus.nWE & (r_s == 3'd6);
  assign w_data_acc = w_ramdec & (r_s == 3'd6);
  assign w_rom_sel  = ~bus.nIOSEL | (~bus.nIOSTRB & r_ioromen);
  assign w_bank_inc = r_bank + BANK_W'(1);

`ifdef XFER_COUNT_EN
  logic [15:0] r_xcnt;

  always_ff @(posedge C7M) begin
    if (RES) begin
      r_xcnt <= 16'h0000;
    end else if (w_reg_wr && (w_off == 4'hC || w_off == 4'hD)) begin
      r_xcnt <= 16'h0000;
    end else if (w_data_acc) begin
      r_xcnt <= r_xcnt + 16'd1;
    end
  end

  assign w_xcnt = r_xcnt;
`else
  assign w_xcnt = 16'h0000;
`endif

  // Bus phase tracking: S restarts at 1 on each PHI1 rise once PHI1 has been low.
  always_ff @(posedge C7M) begin
    if (RES) begin
      r_s        <= 3'd0;
      r_phi1_q   <= 1'b0;
      r_phi0seen <= 1'b0;
      r_dben     <= 1'b0;
      r_csen     <= 1'b0;
      r_regen    <= 1'b0;
      r_ioromen  <= 1'b0;
    end else begin
      r_phi1_q   <= bus.PHI1;
      r_phi0seen <= r_phi0seen | ~bus.PHI1;
      if (r_phi0seen) begin
        if (bus.PHI1 && !r_phi1_q) begin
          r_s <= 3'd1;
        end else if (r_s != 3'd7) begin
          r_s <= r_s + 3'd1;
        end
      end
      r_dben <= r_s[2];
      r_csen <= ((r_s == 3'd4) && bus.nWE) || (r_s >= 3'd5);
      if (r_s == 3'd4 && !bus.nIOSEL) begin
        r_regen <= 1'b1;
      end
      if (r_s == 3'd4) begin
        if (!bus.nIOSTRB && bus.A == 11'h7FF) begin
          r_ioromen <= 1'b0;
        end else if (!bus.nIOSEL) begin
          r_ioromen <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge C7M) begin
    if (RES) begin
      for (int c = 0; c < NCH; c++) begin
        r_addr[c] <= 24'h000000;
      end
      r_mode <= '0;
      r_bank <= '0;
      r_pend <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (r_s == 3'd1 && r_pend[c]) begin
          r_addr[c] <= f_step(r_addr[c], r_mode[2*c +: 2]);
          r_pend[c] <= 1'b0;
        end else if (w_reg_wr && int'(w_ch) == c) begin
          case (w_off[1:0])
            2'd0:    r_addr[c] <= {r_addr[c][23:8], bus.D_in} & c_addr_mask;
            2'd1:    r_addr[c] <= {r_addr[c][23:16], bus.D_in, r_addr[c][7:0]} & c_addr_mask;
            2'd2:    r_addr[c] <= {bus.D_in, r_addr[c][15:0]} & c_addr_mask;
            default: ;
          endcase
        end
        if (w_data_acc && int'(w_ch) == c) begin
          r_pend[c] <= 1'b1;
        end
      end
      if (w_reg_wr && w_off == 4'hE) begin
        r_mode <= bus.D_in[c_mode_w-1:0];
      end
      if (w_reg_wr && w_off == 4'hF) begin
        r_bank <= BANK_W'(bus.D_in);
      end
    end
  end

  always_comb begin
    w_sel_addr = r_addr[0];
    for (int c = 0; c < NCH; c++) begin
      if (w_is_data && int'(w_ch) == c) begin
        w_sel_addr = r_addr[c];
      end
    end
  end

  // ROM strobe window outranks slot ROM, which outranks the DATA pointers.
  always_comb begin
    w_ra = r_addr[0][ADDR_W-1:0];
    if (!bus.nIOSTRB) begin
      w_ra        = '0;
      w_ra[10:0]  = bus.A;
      w_ra[18:11] = 8'(w_bank_inc);
    end else if (!bus.nIOSEL) begin
      w_ra       = '0;
      w_ra[10:0] = bus.A;
    end else if (!bus.nDEVSEL && w_is_data) begin
      w_ra = w_sel_addr[ADDR_W-1:0];
    end
  end

  always_comb begin
    w_reg_rd = 8'h00;
    for (int c = 0; c < NCH; c++) begin
      if (int'(w_ch) == c) begin
        case (w_off[1:0])
          2'd0:    w_reg_rd = r_addr[c][7:0];
          2'd1:    w_reg_rd = r_addr[c][15:8];
          2'd2:    w_reg_rd = r_addr[c][23:16];
          default: w_reg_rd = 8'h00;
        endcase
      end
    end
    case (w_off)
      4'hC:    w_reg_rd = w_xcnt[7:0];
      4'hD:    w_reg_rd = w_xcnt[15:8];
      4'hE:    w_reg_rd = 8'(r_mode);
      4'hF:    w_reg_rd = 8'(r_bank);
      default: ;
    endcase
  end

  assign bus.RA     = w_ra;
  assign bus.RAMCS  = w_ramdec & r_csen;
  assign bus.nROMCS = ~(r_csen & w_rom_sel);
  assign bus.RD_oe  = r_dben & ~bus.nWE & w_ramdec;
  assign bus.D_oe   = r_dben & bus.nWE & (w_dev | w_rom_sel);
  assign bus.D_out  = (w_rom_sel | (~bus.nDEVSEL & w_is_data)) ? bus.RD_in : w_reg_rd;

endmodule
`default_nettype wire

// File: tb/tb_slot_multichannel_ramctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_slot_multichannel_ramctl
// Brief    : Directed self-checking bench for slot_multichannel_ramctl.
// Revision : 1.0  initial release
// ============================================================================
module tb_slot_multichannel_ramctl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  slot_multichannel_ramctl_if #(.ADDR_W(24)) bus ();

  slot_multichannel_ramctl #(
    .NCH    (2),
    .ADDR_W (24),
    .BANK_W (8)
  ) dut (
    .C7M (clk),
    .RES (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic        s_ramcs  [8];
  logic        s_rdoe   [8];
  logic        s_doe    [8];
  logic        s_nromcs [8];
  logic [23:0] s_ra     [8];
  logic [7:0]  s_dout   [8];
  logic [7:0]  rdv = 8'h00;
  logic [7:0]  v;

  // One PHI1 period of 8 clocks; sample k sees S = min(k+1, 7).
  task automatic bus_cycle(input logic dev, input logic iosel, input logic iostrb,
                           input logic [10:0] a, input logic wr, input logic [7:0] d,
                           input int rst_k);
    bus.nDEVSEL = ~dev;
    bus.nIOSEL  = ~iosel;
    bus.nIOSTRB = ~iostrb;
    bus.A       = a;
    bus.nWE     = ~wr;
    bus.D_in    = d;
    bus.RD_in   = rdv;
    bus.PHI1    = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      s_ramcs[k]  = bus.RAMCS;
      s_rdoe[k]   = bus.RD_oe;
      s_doe[k]    = bus.D_oe;
      s_nromcs[k] = bus.nROMCS;
      s_ra[k]     = bus.RA;
      s_dout[k]   = bus.D_out;
      if (k == 3) bus.PHI1 = 1'b0;
      if (k == rst_k) rst = 1'b1;
      if (k == rst_k + 1) rst = 1'b0;
    end
  endtask

  task automatic reg_wr(input logic [3:0] off, input logic [7:0] val);
    bus_cycle(1'b1, 1'b0, 1'b0, {7'd0, off}, 1'b1, val, 99);
  endtask

  task automatic reg_rd(input logic [3:0] off, output logic [7:0] val);
    bus_cycle(1'b1, 1'b0, 1'b0, {7'd0, off}, 1'b0, 8'h00, 99);
    val = s_dout[6];
  endtask

  task automatic test_reset;
    bus.PHI1 = 1'b0; bus.nDEVSEL = 1'b1; bus.nIOSEL = 1'b1; bus.nIOSTRB = 1'b1;
    bus.A = 11'h000; bus.nWE = 1'b1; bus.D_in = 8'h00; bus.RD_in = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.D_oe !== 1'b0) begin bad++; $display("FAIL rst_doe: got %b want 0", bus.D_oe); end
    total++; if (bus.RD_oe !== 1'b0) begin bad++; $display("FAIL rst_rdoe: got %b want 0", bus.RD_oe); end
    total++; if (bus.RAMCS !== 1'b0) begin bad++; $display("FAIL rst_ramcs: got %b want 0", bus.RAMCS); end
    total++; if (bus.nROMCS !== 1'b1) begin bad++; $display("FAIL rst_nromcs: got %b want 1", bus.nROMCS); end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_regen_gate;
    repeat (3) bus_cycle(1'b0, 1'b0, 1'b0, 11'h000, 1'b0, 8'h00, 99);
    reg_wr(4'h0, 8'h12);
    bus_cycle(1'b1, 1'b0, 1'b0, 11'h000, 1'b0, 8'h00, 99);
    total++; if (s_doe[5] !== 1'b0) begin bad++; $display("FAIL noregen_doe: got %b want 0", s_doe[5]); end
    rdv = 8'h77;
    bus_cycle(1'b0, 1'b1, 1'b0, 11'h000, 1'b0, 8'h00, 99);
    total++; if (s_doe[5] !== 1'b1) begin bad++; $display("FAIL iosel_doe: got %b want 1", s_doe[5]); end
    total++; if (s_dout[5] !== 8'h77) begin bad++; $display("FAIL iosel_dout: got %h want 77", s_dout[5]); end
    total++; if (s_nromcs[5] !== 1'b0) begin bad++; $display("FAIL iosel_nromcs: got %b want 0", s_nromcs[5]); end
    reg_rd(4'h0, v);
    total++; if (v !== 8'h00) begin bad++; $display("FAIL ignored_wr: got %h want 00", v); end
  endtask

  task automatic test_ch0_step;
    reg_wr(4'h2, 8'h0F);
    reg_wr(4'h1, 8'hFF);
    reg_wr(4'h0, 8'hFF);
    rdv = 8'h3C;
    bus_cycle(1'b1, 1'b0, 1'b0, 11'h003, 1'b0, 8'h00, 99);
    total++; if ({s_ramcs[3], s_ramcs[4], s_ramcs[5], s_ramcs[6]} !== 4'b0111) begin
      bad++; $display("FAIL ch0_ramcs: got %b%b%b%b want 0111", s_ramcs[3], s_ramcs[4], s_ramcs[5], s_ramcs[6]);
    end
    total++; if (s_ra[5] !== 24'h0FFFFF) begin bad++; $display("FAIL ch0_ra: got %h want 0fffff", s_ra[5]); end
    total++; if (s_dout[5] !== 8'h3C) begin bad++; $display("FAIL ch0_dout: got %h want 3c", s_dout[5]); end
    reg_rd(4'h2, v);
    total++; if (v !== 8'h10) begin bad++; $display("FAIL ch0_addrh: got %h want 10", v); end
    reg_rd(4'h1, v);
    total++; if (v !== 8'h00) begin bad++; $display("FAIL ch0_addrm: got %h want 00", v); end
    reg_rd(4'h0, v);
    total++; if (v !== 8'h00) begin bad++; $display("FAIL ch0_addrl: got %h want 00", v); end
  endtask

  task automatic test_ch1_dec;
    reg_wr(4'hE, 8'h08);
    reg_wr(4'h4, 8'h00);
    reg_wr(4'h5, 8'h00);
    reg_wr(4'h6, 8'h00);
    bus_cycle(1'b1, 1'b0, 1'b0, 11'h007, 1'b1, 8'hA5, 99);
    total++; if ({s_rdoe[3], s_rdoe[4], s_rdoe[5], s_rdoe[6]} !== 4'b0111) begin
      bad++; $display("FAIL ch1_rdoe: got %b%b%b%b want 0111", s_rdoe[3], s_rdoe[4], s_rdoe[5], s_rdoe[6]);
    end
    total++; if (s_ra[5] !== 24'h000000) begin bad++; $display("FAIL ch1_ra: got %h want 000000", s_ra[5]); end
    total++; if ({s_ramcs[4], s_ramcs[5]} !== 2'b01) begin
      bad++; $display("FAIL ch1_ramcs: got %b%b want 01", s_ramcs[4], s_ramcs[5]);
    end
    total++; if (s_doe[5] !== 1'b0) begin bad++; $display("FAIL ch1_doe: got %b want 0", s_doe[5]); end
    reg_rd(4'h4, v);
    total++; if (v !== 8'hFF) begin bad++; $display("FAIL ch1_addrl: got %h want ff", v); end
    reg_rd(4'h5, v);
    total++; if (v !== 8'hFF) begin bad++; $display("FAIL ch1_addrm: got %h want ff", v); end
    reg_rd(4'h6, v);
    total++; if (v !== 8'hFF) begin bad++; $display("FAIL ch1_addrh: got %h want ff", v); end
    reg_rd(4'h2, v);
    total++; if (v !== 8'h10) begin bad++; $display("FAIL ch0_untouched: got %h want 10", v); end
    reg_rd(4'hE, v);
    total++; if (v !== 8'h08) begin bad++; $display("FAIL mode_rd: got %h want 08", v); end
  endtask

  task automatic test_ch0_wrap;
    reg_wr(4'h2, 8'hFF);
    reg_wr(4'h1, 8'hFF);
    reg_wr(4'h0, 8'hFF);
    bus_cycle(1'b1, 1'b0, 1'b0, 11'h003, 1'b0, 8'h00, 99);
    reg_rd(4'h0, v);
    total++; if (v !== 8'h00) begin bad++; $display("FAIL wrap_addrl: got %h want 00", v); end
    reg_rd(4'h2, v);
    total++; if (v !== 8'h00) begin bad++; $display("FAIL wrap_addrh: got %h want 00", v); end
  endtask

  task automatic test_rom_bank;
    reg_wr(4'hF, 8'h07);
    reg_rd(4'hF, v);
    total++; if (v !== 8'h07) begin bad++; $display("FAIL bank_rd: got %h want 07", v); end
    rdv = 8'hC3;
    bus_cycle(1'b0, 1'b0, 1'b1, 11'h7F0, 1'b0, 8'h00, 99);
    total++; if (s_ra[5] !== 24'h0047F0) begin bad++; $display("FAIL cff0_ra: got %h want 0047f0", s_ra[5]); end
    total++; if (s_nromcs[5] !== 1'b0) begin bad++; $display("FAIL cff0_nromcs: got %b want 0", s_nromcs[5]); end
    total++; if (s_doe[5] !== 1'b1) begin bad++; $display("FAIL cff0_doe: got %b want 1", s_doe[5]); end
    total++; if (s_dout[5] !== 8'hC3) begin bad++; $display("FAIL cff0_dout: got %h want c3", s_dout[5]); end
    bus_cycle(1'b0, 1'b0, 1'b1, 11'h7FF, 1'b0, 8'h00, 99);
    bus_cycle(1'b0, 1'b0, 1'b1, 11'h000, 1'b0, 8'h00, 99);
    total++; if (s_nromcs[5] !== 1'b1) begin bad++; $display("FAIL c800_nromcs: got %b want 1", s_nromcs[5]); end
    total++; if (s_doe[5] !== 1'b0) begin bad++; $display("FAIL c800_doe: got %b want 0", s_doe[5]); end
    total++; if (s_ra[5] !== 24'h004000) begin bad++; $display("FAIL c800_ra: got %h want 004000", s_ra[5]); end
    reg_wr(4'hF, 8'hFF);
    bus_cycle(1'b0, 1'b0, 1'b1, 11'h123, 1'b0, 8'h00, 99);
    total++; if (s_ra[5] !== 24'h000123) begin bad++; $display("FAIL bank_wrap_ra: got %h want 000123", s_ra[5]); end
  endtask

  task automatic test_reset_mid;
    reg_wr(4'h2, 8'h00);
    reg_wr(4'h1, 8'h00);
    reg_wr(4'h0, 8'h00);
    bus_cycle(1'b1, 1'b0, 1'b0, 11'h003, 1'b0, 8'h00, 5);
    total++; if (s_doe[6] !== 1'b0) begin bad++; $display("FAIL midrst_doe: got %b want 0", s_doe[6]); end
    total++; if (s_ramcs[6] !== 1'b0) begin bad++; $display("FAIL midrst_ramcs: got %b want 0", s_ramcs[6]); end
    total++; if (s_nromcs[6] !== 1'b1) begin bad++; $display("FAIL midrst_nromcs: got %b want 1", s_nromcs[6]); end
    bus_cycle(1'b1, 1'b0, 1'b0, 11'h000, 1'b0, 8'h00, 99);
    total++; if (s_doe[5] !== 1'b0) begin bad++; $display("FAIL midrst_regen: got %b want 0", s_doe[5]); end
    bus_cycle(1'b0, 1'b1, 1'b0, 11'h000, 1'b0, 8'h00, 99);
    reg_rd(4'h0, v);
    total++; if (v !== 8'h00) begin bad++; $display("FAIL midrst_nostep: got %h want 00", v); end
    reg_rd(4'h4, v);
    total++; if (v !== 8'h00) begin bad++; $display("FAIL midrst_ch1: got %h want 00", v); end
    reg_rd(4'hE, v);
    total++; if (v !== 8'h00) begin bad++; $display("FAIL midrst_mode: got %h want 00", v); end
  endtask

  task automatic test_xcnt;
`ifdef XFER_COUNT_EN
    reg_wr(4'hC, 8'h00);
    for (int i = 0; i < 300; i++) begin
      bus_cycle(1'b1, 1'b0, 1'b0, 11'h003, 1'b0, 8'h00, 99);
    end
    reg_rd(4'hC, v);
    total++; if (v !== 8'h2C) begin bad++; $display("FAIL xcnt_lo: got %h want 2c", v); end
    reg_rd(4'hD, v);
    total++; if (v !== 8'h01) begin bad++; $display("FAIL xcnt_hi: got %h want 01", v); end
    reg_wr(4'hC, 8'h55);
    reg_rd(4'hC, v);
    total++; if (v !== 8'h00) begin bad++; $display("FAIL xcnt_clr_lo: got %h want 00", v); end
    reg_rd(4'hD, v);
    total++; if (v !== 8'h00) begin bad++; $display("FAIL xcnt_clr_hi: got %h want 00", v); end
`else
    bus_cycle(1'b1, 1'b0, 1'b0, 11'h003, 1'b0, 8'h00, 99);
    reg_wr(4'hC, 8'h55);
    reg_rd(4'hC, v);
    total++; if (v !== 8'h00) begin bad++; $display("FAIL rsvd_c: got %h want 00", v); end
    reg_rd(4'hD, v);
    total++; if (v !== 8'h00) begin bad++; $display("FAIL rsvd_d: got %h want 00", v); end
`endif
  endtask

  initial begin
    test_reset();
    test_regen_gate();
    test_ch0_step();
    test_ch1_dec();
    test_ch0_wrap();
    test_rom_bank();
    test_reset_mid();
    test_xcnt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
